// File: rtl/sr_display_scheduler_if.sv
// Bundle between the display scheduler and the software/driver side:
// driver load tick, scan enable, shadow-bank writes, commit handshake and the parallel word.
interface sr_display_scheduler_if;
  logic        load_tick_i;
  logic        enable_i;
  logic        wr_en_i;
  logic [2:0]  wr_addr_i;
  logic [7:0]  wr_data_i;
  logic        commit_req_i;
  logic        commit_busy_o;
  logic        commit_ack_o;
  logic        frame_o;
  logic [2:0]  digit_o;
  logic [15:0] data_o;

  modport slave (
    input  load_tick_i,
    input  enable_i,
    input  wr_en_i,
    input  wr_addr_i,
    input  wr_data_i,
    input  commit_req_i,
    output commit_busy_o,
    output commit_ack_o,
    output frame_o,
    output digit_o,
    output data_o
  );

  modport master (
    output load_tick_i,
    output enable_i,
    output wr_en_i,
    output wr_addr_i,
    output wr_data_i,
    output commit_req_i,
    input  commit_busy_o,
    input  commit_ack_o,
    input  frame_o,
    input  digit_o,
    input  data_o
  );
endinterface

// File: rtl/sr_display_scheduler.sv
// Time-multiplexed digit scanner for a 16-bit 595 chain: blank slot before each digit,
// double-buffered segment bank with commits applied atomically at frame end.
module sr_display_scheduler #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned DWELL          = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n_i,
  sr_display_scheduler_if.slave   bus
);

  localparam int unsigned DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [7:0]  SEG_MASK   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]  DIG_MASK   = DIG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [15:0] OFF_WORD   = {DIG_MASK, SEG_MASK};
  localparam logic [2:0]  LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic [DW_W-1:0] LAST_DWELL = DW_W'(DWELL - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t            r_state;
  logic [2:0]        r_digit;
  logic [DW_W-1:0]   r_dwell;
  logic [15:0]       r_data;
  logic              r_busy;
  logic              r_ack;
  logic              r_frame;
  logic [7:0]        r_shadow [8];
  logic [7:0]        r_active [8];

  logic              w_tick;
  logic              w_dwell_done;
  logic              w_last_digit;
  logic              w_frame_end;
  logic              w_commit_fire;
  logic              w_wr_ok;
  logic [2:0]        w_digit_next;
  logic [7:0]        w_dig_onehot;
  logic [15:0]       w_show_word;

  assign w_tick       = bus.load_tick_i;
  assign w_dwell_done = (r_dwell == LAST_DWELL);
  assign w_last_digit = (r_digit == LAST_DIGIT);
  assign w_digit_next = w_last_digit ? 3'd0 : r_digit + 3'd1;

  // A disabled tick is always a frame end, so commits still drain while the scan is off.
  assign w_frame_end   = w_tick && (!bus.enable_i ||
                         (r_state == ST_SHOW && w_dwell_done && w_last_digit));
  assign w_commit_fire = w_frame_end && (r_busy || bus.commit_req_i);

  assign w_wr_ok      = bus.wr_en_i && ({1'b0, bus.wr_addr_i} < 4'(NUM_DIGITS));
  assign w_dig_onehot = 8'b0000_0001 << r_digit;
  assign w_show_word  = {w_dig_onehot ^ DIG_MASK, r_active[r_digit] ^ SEG_MASK};

  // Scan state machine and registered outputs.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_BLANK;
      r_digit <= 3'd0;
      r_dwell <= '0;
      r_data  <= OFF_WORD;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_frame_end;
      r_ack   <= w_commit_fire;
      if (w_commit_fire) begin
        r_busy <= 1'b0;
      end else if (bus.commit_req_i) begin
        r_busy <= 1'b1;
      end

      if (w_tick) begin
        if (!bus.enable_i) begin
          r_state <= ST_BLANK;
          r_digit <= 3'd0;
          r_dwell <= '0;
          r_data  <= OFF_WORD;
        end else begin
          case (r_state)
            ST_BLANK: begin
              r_state <= ST_SHOW;
              r_dwell <= '0;
              r_data  <= w_show_word;
            end
            ST_SHOW: begin
              if (w_dwell_done) begin
                r_state <= ST_BLANK;
                r_data  <= OFF_WORD;
                r_digit <= w_digit_next;
              end else begin
                r_dwell <= r_dwell + 1'b1;
              end
            end
            default: begin
              r_state <= ST_BLANK;
              r_data  <= OFF_WORD;
            end
          endcase
        end
      end
    end
  end

  // Commit copies the pre-write shadow; a same-cycle write only reaches the shadow.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= 8'h00;
        r_active[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_commit_fire) begin
          r_active[i] <= r_shadow[i];
        end
        if (w_wr_ok && (bus.wr_addr_i == 3'(i))) begin
          r_shadow[i] <= bus.wr_data_i;
        end
      end
    end
  end

  assign bus.data_o        = r_data;
  assign bus.digit_o       = r_digit;
  assign bus.commit_busy_o = r_busy;
  assign bus.commit_ack_o  = r_ack;
  assign bus.frame_o       = r_frame;

endmodule

// File: tb/tb_sr_display_scheduler.sv
// Bench for sr_display_scheduler (4 digits, dwell 2): directed scenarios plus random traffic,
// every clock compared against a slot-position reference model.
module tb_sr_display_scheduler;
  localparam int ND    = 4;
  localparam int DW    = 2;
  localparam int FRAME = ND * (DW + 1);
  localparam logic [15:0] OFF = 16'hFFFF;

  logic clk = 1'b0;
  logic rst_n_i;
  sr_display_scheduler_if bus_if ();

  sr_display_scheduler #(
    .NUM_DIGITS(ND),
    .DWELL(DW),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n_i(rst_n_i),
    .bus(bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int ph = 0;
  int n_ack_seen = 0;

  // Reference model: position within the frame is derived from the count of enabled ticks.
  int          m_k;
  bit          m_pending;
  logic [7:0]  m_shadow [ND];
  logic [7:0]  m_active [ND];
  logic [15:0] e_data;
  logic [2:0]  e_digit;
  bit          e_frame;
  bit          e_ack;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] show_word(input int dd, input logic [7:0] seg);
    logic [7:0] dig;
    dig = 8'h01 << dd;
    return {~dig, ~seg};
  endfunction

  task automatic m_reset();
    m_k = 0;
    m_pending = 1'b0;
    for (int i = 0; i < ND; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    e_data  = OFF;
    e_digit = 3'd0;
    e_frame = 1'b0;
    e_ack   = 1'b0;
  endtask

  task automatic model_update(input bit t, input bit en, input bit w, input logic [2:0] a,
                              input logic [7:0] d, input bit r);
    int p;
    int dd;
    int rr;
    bit fe;
    fe = 1'b0;
    if (t) begin
      if (!en) begin
        m_k = 0;
        e_digit = 3'd0;
        e_data = OFF;
        fe = 1'b1;
      end else begin
        m_k++;
        p  = (m_k - 1) % FRAME;
        dd = p / (DW + 1);
        rr = p % (DW + 1);
        if (rr < DW) begin
          e_digit = 3'(dd);
          if (rr == 0) e_data = show_word(dd, m_active[dd]);
        end else begin
          e_digit = 3'((dd + 1) % ND);
          e_data = OFF;
          fe = (dd == ND - 1);
        end
      end
    end
    e_frame = fe;
    e_ack = fe && (m_pending || r);
    if (e_ack) begin
      m_active = m_shadow;
      m_pending = 1'b0;
    end else if (r) begin
      m_pending = 1'b1;
    end
    if (w && (int'(a) < ND)) m_shadow[a] = d;
  endtask

  function automatic bit next_fe();
    return (m_k % FRAME) == FRAME - 1;
  endfunction

  function automatic bit showing(input int dig, input bit any);
    int p;
    if (m_k == 0) return 1'b0;
    p = (m_k - 1) % FRAME;
    return ((p % (DW + 1)) < DW) && (any || (p / (DW + 1)) == dig);
  endfunction

  task automatic check_all();
    chk("data_o", bus_if.data_o, e_data);
    chk("digit_o", 16'(bus_if.digit_o), 16'(e_digit));
    chk("frame_o", 16'(bus_if.frame_o), 16'(e_frame));
    chk("commit_ack_o", 16'(bus_if.commit_ack_o), 16'(e_ack));
    chk("commit_busy_o", 16'(bus_if.commit_busy_o), 16'(m_pending));
  endtask

  task automatic clk_cycle(input bit en, input bit w, input logic [2:0] a,
                           input logic [7:0] d, input bit r);
    bit t;
    t = (ph == 0);
    bus_if.load_tick_i  = t;
    bus_if.enable_i     = en;
    bus_if.wr_en_i      = w;
    bus_if.wr_addr_i    = a;
    bus_if.wr_data_i    = d;
    bus_if.commit_req_i = r;
    @(posedge clk);
    #1;
    model_update(t, en, w, a, d, r);
    check_all();
    if (bus_if.commit_ack_o === 1'b1) n_ack_seen++;
    ph = (ph + 1) % 16;
    bus_if.load_tick_i  = 1'b0;
    bus_if.wr_en_i      = 1'b0;
    bus_if.commit_req_i = 1'b0;
  endtask

  task automatic tick_op(input bit en, input bit w, input logic [2:0] a,
                         input logic [7:0] d, input bit r);
    while (ph != 0) clk_cycle(en, 1'b0, 3'd0, 8'h00, 1'b0);
    clk_cycle(en, w, a, d, r);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  task automatic goto_fe();
    for (int i = 0; i < FRAME && !next_fe(); i++) tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          r_en;
    bit          r_w;
    bit          r_r;
    logic [2:0]  r_a;
    logic [7:0]  r_d;

    rst_n_i = 1'b0;
    bus_if.load_tick_i  = 1'b0;
    bus_if.enable_i     = 1'b1;
    bus_if.wr_en_i      = 1'b0;
    bus_if.wr_addr_i    = 3'd0;
    bus_if.wr_data_i    = 8'h00;
    bus_if.commit_req_i = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n_i = 1'b1;
    ph = 0;

    // Empty bank: digit 0 lit with no segments, then blanks and the other digits.
    tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("first_show", bus_if.data_o, 16'hFEFF);
    run_ticks(2 * FRAME - 1);

    // Load shadow and commit mid-frame.
    clk_cycle(1'b1, 1'b1, 3'd0, 8'h3F, 1'b0);
    clk_cycle(1'b1, 1'b1, 3'd1, 8'h06, 1'b0);
    clk_cycle(1'b1, 1'b1, 3'd2, 8'h5B, 1'b0);
    clk_cycle(1'b1, 1'b1, 3'd3, 8'h4F, 1'b0);
    clk_cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
    chk("busy_after_req", 16'(bus_if.commit_busy_o), 16'd1);
    goto_fe();
    tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("ack_at_frame_end", 16'(bus_if.commit_ack_o), 16'd1);
    chk("busy_cleared", 16'(bus_if.commit_busy_o), 16'd0);
    tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("digit0_show", bus_if.data_o, 16'hFEC0);
    tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("digit0_hold", bus_if.data_o, 16'hFEC0);
    tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("blank_slot", bus_if.data_o, OFF);
    tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("digit1_show", bus_if.data_o, 16'hFDF9);

    // Commit request on the frame-end tick with a simultaneous write to digit 1.
    goto_fe();
    tick_op(1'b1, 1'b1, 3'd1, 8'hAA, 1'b1);
    chk("same_tick_ack", 16'(bus_if.commit_ack_o), 16'd1);
    chk("same_tick_frame", 16'(bus_if.frame_o), 16'd1);
    run_ticks(4);
    chk("old_shadow_used", bus_if.data_o, 16'hFDF9);
    clk_cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
    goto_fe();
    tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    run_ticks(4);
    chk("new_value_shown", bus_if.data_o, 16'hFD55);

    // Out-of-range addresses are ignored.
    clk_cycle(1'b1, 1'b1, 3'd6, 8'h00, 1'b0);
    clk_cycle(1'b1, 1'b1, 3'd7, 8'h12, 1'b0);
    clk_cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
    goto_fe();
    tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("ignored_wr_ack", 16'(bus_if.commit_ack_o), 16'd1);
    run_ticks(4);
    chk("ignored_wr_d1", bus_if.data_o, 16'hFD55);
    run_ticks(3);
    chk("ignored_wr_d2", bus_if.data_o, 16'hFBA4);

    // Drop enable while digit 2 is shown.
    for (int i = 0; i < FRAME && !showing(2, 1'b0); i++) tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    tick_op(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("disable_data", bus_if.data_o, OFF);
    chk("disable_digit", 16'(bus_if.digit_o), 16'd0);
    chk("disable_frame", 16'(bus_if.frame_o), 16'd1);
    tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("reenable_digit", 16'(bus_if.digit_o), 16'd0);
    chk("reenable_data", bus_if.data_o, 16'hFEC0);

    // Random traffic.
    while (ph != 0) clk_cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    for (int t = 0; t < 60; t++) begin
      r_en = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < 16; c++) begin
        r_w = ($urandom_range(0, 2) == 0);
        r_a = 3'($urandom_range(0, 7));
        r_d = 8'($urandom);
        r_r = ($urandom_range(0, 19) == 0);
        clk_cycle(r_en, r_w, r_a, r_d, r_r);
      end
    end

    // Asynchronous reset between ticks with a commit pending.
    tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    for (int i = 0; i < FRAME && !showing(0, 1'b1); i++) tick_op(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    clk_cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
    chk("pending_before_rst", 16'(bus_if.commit_busy_o), 16'd1);
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("rst_data", bus_if.data_o, OFF);
    chk("rst_digit", 16'(bus_if.digit_o), 16'd0);
    chk("rst_busy", 16'(bus_if.commit_busy_o), 16'd0);
    chk("rst_ack", 16'(bus_if.commit_ack_o), 16'd0);
    chk("rst_frame", 16'(bus_if.frame_o), 16'd0);
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    ph = 0;
    n_ack_seen = 0;
    run_ticks(FRAME + 2);
    chk("no_ack_after_reset", 16'(n_ack_seen), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sr_display_scheduler.md
# sr_display_scheduler

Time-multiplexed display scheduler feeding the 16-bit serial shift-register driver (segments plus digit enables on one 595 chain). It holds a double-buffered bank of per-digit segment patterns, steps through the digits once per frame, inserts a blanking slot before each digit to suppress ghosting, and presents a stable 16-bit word that the driver reloads on every `load_enable` pulse. Software-side writers update a shadow bank; a commit request is applied atomically at the next frame boundary.

## Interface
- `NUM_DIGITS`, default 8: digits scanned; legal range 1..8.
- `DWELL`, default 4: consecutive show slots per digit; must be >= 1.
- `SEG_ACTIVE_LOW`, default 1: segment bits inverted on `data_o[7:0]`.
- `DIG_ACTIVE_LOW`, default 1: digit-enable bits inverted on `data_o[15:8]`.
- `clk`  in  1  clock; the driver runs on the same clock.
- `rst_n_i`  in  1  reset: asynchronous, active-low.
- `load_tick_i`  in  1  driver's `load_enable`; one-cycle pulse every 16 clocks.
- `enable_i`  in  1  scan enable; when low, output is forced blank.
- `wr_en_i`  in  1  write strobe into the shadow bank.
- `wr_addr_i`  in  3  digit index; writes with index >= NUM_DIGITS are ignored.
- `wr_data_i`  in  8  logical segment pattern; 1 = lit (bit 7 = dp).
- `commit_req_i`  in  1  one-cycle request to copy shadow to active at the next frame end.
- `commit_busy_o`  out  1  commit pending.
- `commit_ack_o`  out  1  one-cycle pulse on the tick where the copy happens.
- `frame_o`  out  1  one-cycle pulse on each frame-end tick.
- `digit_o`  out  3  digit currently being shown or blanked.
- `data_o`  out  16  parallel word to the driver: [7:0] segments, [15:8] digit enables (bit 8+d = digit d).

## Operation
- Off word is segments all off and digits all off, with polarity applied. With the default parameters this is 16'hFFFF.
- Reset values:
  - `data_o` = off word.
  - State BLANK, `digit_o` = 0, dwell counter = 0.
  - Shadow and active banks all 0.
  - `commit_busy_o`, `commit_ack_o` and `frame_o` = 0.
- All state advances only on cycles with `load_tick_i` = 1 (a tick). Between ticks, `data_o`, `digit_o` and the state are held.
- FSM on each tick, with `enable_i` = 1:
  - BLANK -> SHOW: dwell counter = 0; `data_o` = {enable bit for `digit_o`, active[`digit_o`]}, with polarity applied.
  - SHOW, dwell counter < DWELL-1: increment the counter; `data_o` held.
  - SHOW, dwell counter == DWELL-1 -> BLANK: `data_o` = off word; `digit_o` advances to the next digit, wrapping NUM_DIGITS-1 to 0. Wrapping to 0 is a frame end.
- Tick with `enable_i` = 0: state goes to BLANK, `digit_o` = 0, `data_o` = off word. Every such tick counts as a frame end.
- Frame end: `frame_o` pulses. If a commit is pending or `commit_req_i` is high in the same cycle:
  - active bank <= shadow bank, all digits at once;
  - `commit_ack_o` pulses and pending is cleared.
- `commit_req_i` outside a frame-end tick sets pending, so `commit_busy_o` goes high on the next clock. Repeated requests while pending merge into one commit.
- A shadow write in the same cycle as a commit lands in the shadow bank only. The copy uses the pre-write shadow contents.
- Writes are accepted on any clock, tick or not, and never touch the active bank directly.
- Frame length = NUM_DIGITS*(DWELL+1) ticks.

## Timing
- `data_o` is registered and changes only on the clock edge of a tick. The driver latches `data_in` on that same edge, so each new word reaches the driver on the following tick, 16 clocks later. This one-slot pipeline lag is fixed; the blanking slot keeps it glitch-free.
- `commit_ack_o` and `frame_o` are registered, asserted for the one cycle after the tick edge.
- Commit latency ranges from 0 ticks (request on the frame-end tick) to one full frame.
- Asynchronous reset mid-frame: all outputs return to their reset values immediately. Pending commits and both banks are lost.
- Reset is released synchronously to `clk`. The first tick after release moves BLANK -> SHOW for digit 0.

## Test plan
- Reset, then ticks with defaults and all-zero active bank -> `data_o` alternates 16'hFFFF (blank) and 16'hFEFF (digit 0 on, no segments). `digit_o` steps 0..7, `frame_o` every 40 ticks.
- NUM_DIGITS=4, DWELL=2:
  - Write shadow 0..3 = 8'h3F, 8'h06, 8'h5B, 8'h4F, commit mid-frame -> `commit_busy_o` high until the frame-end tick, then `commit_ack_o` pulses.
  - Next frame shows 16'hFEC0 for 2 ticks, blank, 16'hFDF9, ...
- Commit request on the exact frame-end tick with a simultaneous write to digit 1 -> ack in that cycle. Active[1] gets the old shadow value; the new value is shown only after the next commit.
- Write to `wr_addr_i`=6 with NUM_DIGITS=4 -> shadow unchanged; a subsequent commit leaves the display unchanged.
- Drop `enable_i` during SHOW of digit 2 -> next tick `data_o` = 16'hFFFF, `digit_o`=0, `frame_o` pulses. Re-enable -> scan restarts BLANK -> SHOW at digit 0.
- Assert `rst_n_i` low between ticks while a commit is pending -> outputs reset immediately without waiting for `clk`; `commit_ack_o` never fires.
